// File: rtl/fft_bin_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fft_bin_frame_ctrl                                             |
// | Brief   : Shadow/display double buffer for FFT bar magnitudes, swapped   |
// |           on vsync. Optional macro PEAK_HOLD_EN enables decaying peaks.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fft_bin_frame_ctrl #(
    parameter int NUM_BINS   = 10,
    parameter int VAL_W      = 12,
    parameter int DECAY_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fft_valid,
    output logic             fft_ready,
    input  logic [7:0]       fft_bin,
    input  logic [VAL_W-1:0] fft_value,
    input  logic             fft_last,
    input  logic             vsync,
    input  logic [7:0]       rd_bin,
    output logic [VAL_W-1:0] rd_value,
    output logic             frame_swapped,
    output logic [7:0]       skipped_frames
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ready;
    logic             w_xfer;
    logic             w_swap;
    logic             w_skip;
    logic [VAL_W-1:0] r_shadow   [NUM_BINS];
    logic [VAL_W-1:0] r_disp     [NUM_BINS];
    logic [VAL_W-1:0] w_swap_val [NUM_BINS];
    logic [VAL_W-1:0] w_rd;

    assign fft_ready = r_ready;
    assign w_xfer    = fft_valid & r_ready;
    assign w_swap    = vsync & (r_state == S_FULL);
    // A vsync that finds no complete frame waiting is a missed display update.
    assign w_skip    = vsync & (r_state != S_FULL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_xfer) begin
                    w_next = fft_last ? S_FULL : S_FILL;
                end
            end
            S_FULL: begin
                if (vsync) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_ready        <= 1'b0;
            frame_swapped  <= 1'b0;
            skipped_frames <= 8'd0;
        end else begin
            r_state       <= w_next;
            // Ready follows the next state so no beat sneaks in after fft_last.
            r_ready       <= (w_next != S_FULL);
            frame_swapped <= w_swap;
            if (w_skip && (skipped_frames != 8'hFF)) begin
                skipped_frames <= skipped_frames + 8'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
`ifdef PEAK_HOLD_EN
            localparam logic [VAL_W-1:0] c_DECAY = VAL_W'(DECAY_STEP);
            logic [VAL_W-1:0] w_decayed;
            assign w_decayed      = (r_disp[gi] > c_DECAY) ? (r_disp[gi] - c_DECAY) : '0;
            assign w_swap_val[gi] = (r_shadow[gi] > w_decayed) ? r_shadow[gi] : w_decayed;
`else
            logic w_unused_decay;
            assign w_unused_decay = |DECAY_STEP;
            assign w_swap_val[gi] = r_shadow[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_shadow[i] <= '0;
                r_disp[i]   <= '0;
            end
        end else begin
            // Out-of-range bins match no entry and are silently dropped.
            for (int i = 0; i < NUM_BINS; i++) begin
                if (w_xfer && (fft_bin == 8'(i))) begin
                    r_shadow[i] <= fft_value;
                end
                if (w_swap) begin
                    r_disp[i] <= w_swap_val[i];
                end
            end
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (rd_bin == 8'(i)) begin
                w_rd = r_disp[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_value <= '0;
        end else begin
            rd_value <= w_rd;
        end
    end

endmodule
`default_nettype wire

// File: doc/fft_bin_frame_ctrl.md
# fft_bin_frame_ctrl

Frame-synchronous controller between the FFT magnitude producer and the bar-display datapath. It accepts one frame of per-bin magnitudes over a valid/ready stream into a shadow buffer. It holds the producer off until vertical blanking, then swaps the frame into a display buffer so bars never tear mid-scan. It serves the display's per-pixel bin requests from that buffer with fixed one-cycle latency.

## Interface
- NUM_BINS, 10, number of frequency bins displayed (1..255)
- VAL_W, 12, magnitude width in bits
- DECAY_STEP, 16, per-frame peak decay amount (used only with PEAK_HOLD_EN)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- fft_valid  in  1  producer beat valid
- fft_ready  out  1  controller can accept a beat
- fft_bin  in  8  bin index of current beat
- fft_value  in  VAL_W  magnitude of current beat
- fft_last  in  1  final beat of frame
- vsync  in  1  one-cycle pulse at start of vertical blanking
- rd_bin  in  8  bin requested by display
- rd_value  out  VAL_W  magnitude of rd_bin, registered
- frame_swapped  out  1  one-cycle pulse when display buffer updated
- skipped_frames  out  8  saturating count of vsyncs with no complete frame pending

## Operation
- Storage: shadow[NUM_BINS] and disp[NUM_BINS], each VAL_W bits, registers.
- A beat transfers when fft_valid && fft_ready.
- FSM states:
  - IDLE: fft_ready=1. A transfer writes shadow[fft_bin] and goes to FILL, or to FULL if fft_last is set.
  - FILL: fft_ready=1. Each transfer writes shadow[fft_bin]. A transfer with fft_last goes to FULL.
  - FULL: fft_ready=0. On vsync: swap, assert frame_swapped, go to IDLE.
- Transfers with fft_bin >= NUM_BINS are accepted and discarded; fft_last on such a beat still completes the frame.
- Bins not written during a frame keep their previous shadow value.
- Swap, all bins in one cycle: disp[i] <= shadow[i]. The shadow buffer is not cleared.
- vsync in IDLE or FILL: no swap; skipped_frames increments, saturating at 255. The FSM state is unchanged and the partial frame continues.
- vsync in the same cycle as the fft_last transfer (FILL/IDLE): the beat is written, the state moves to FULL, no swap, and skipped_frames increments. The swap happens at the next vsync.
- Read: rd_value <= (rd_bin < NUM_BINS) ? disp[rd_bin] : 0.
- Reset: state IDLE, both buffers 0, rd_value=0, frame_swapped=0, skipped_frames=0, fft_ready=0 during the reset cycle and 1 after.
- A reset mid-frame discards the partial frame with no swap.

## Timing
- Write latency: a value accepted at edge N is in shadow after edge N.
- fft_ready falls on the edge after the fft_last transfer. It is registered from state, with no combinational path from fft_valid.
- Swap latency: vsync sampled at edge N in FULL. disp is updated and frame_swapped=1 after edge N. fft_ready=1 after edge N.
- Read latency is exactly 1 cycle.
- A read and a swap at the same edge return the pre-swap disp value; the new value appears from the next edge.
- Minimum frame-to-display latency: one vsync after fft_last.

## Configuration
- PEAK_HOLD_EN defined:
  - Swap computes disp[i] <= max(shadow[i], sat0(disp[i] - DECAY_STEP)), where sat0 clamps below at 0.
  - Comparison is unsigned VAL_W.
  - Bars rise instantly and fall by at most DECAY_STEP per swapped frame.
- PEAK_HOLD_EN undefined: plain copy disp[i] <= shadow[i]. DECAY_STEP has no effect.

## Test plan
- Reset, then write bins 0..9 with values 100..109, last on bin 9, then vsync. Required: frame_swapped pulses once; rd_bin=3 returns 103 one cycle later; rd_bin=12 returns 0.
- After the fft_last transfer, hold fft_valid=1 with no vsync for 50 cycles. Required: fft_ready=0 throughout, shadow unchanged; after vsync, fft_ready=1 on the next cycle.
- Pulse vsync three times while in FILL. Required: skipped_frames=3, no frame_swapped. Complete the frame and pulse vsync: one swap.
- fft_last transfer and vsync in the same cycle. Required: no swap, skipped_frames+1; the next vsync swaps.
- Beat with fft_bin=200, fft_value=4095, fft_last=1, then vsync. Required: a swap occurs; all rd_value unchanged from the prior frame.
- With PEAK_HOLD_EN, DECAY_STEP=16:
  - Frame 1: bin0=500, swap → 500.
  - Frame 2: bin0=100, swap → 484.
  - Frame 3: bin0=600, swap → 600.
  - Without the macro, frame 2 gives 100.
  - Assert rst_n=0 mid-frame: all outputs return to reset values.
